// File: rtl/acq_buffer_streamer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : acq_buffer_streamer_pkg
//  Description : Shared definitions for the acquisition buffer streamer:
//                framed word-type codes, FSM state encoding, buffer depth
//                and a small word-packing helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package acq_buffer_streamer_pkg;

    localparam int MAX_DEPTH = 1024;
    localparam int PAYLOAD_W = 14;

    // Word-type codes carried in out_data[15:14]
    localparam logic [1:0] TYPE_HDR_A = 2'b10;
    localparam logic [1:0] TYPE_HDR_B = 2'b11;
    localparam logic [1:0] TYPE_SMP_A = 2'b00;
    localparam logic [1:0] TYPE_SMP_B = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_HDR_A      = 3'd1,
        S_FETCH_A    = 3'd2,
        S_SEND_A     = 3'd3,
        S_HDR_B      = 3'd4,
        S_FETCH_B    = 3'd5,
        S_SEND_B     = 3'd6,
        S_WAIT_CLEAR = 3'd7
    } state_t;

    function automatic logic [15:0] make_word(input logic [1:0]           typ,
                                              input logic [PAYLOAD_W-1:0] payload);
        return {typ, payload};
    endfunction

endpackage
`default_nettype wire

// File: rtl/acq_buffer_streamer_if.sv
`default_nettype none
// ============================================================================
//  Module      : acq_buffer_streamer_if
//  Description : Bus bundle between the streamer, the two-channel sampler
//                read port and the downstream word link.
//                master : streamer side (drives read_index, out_*, status)
//                slave  : environment side (drives ready flags, counts,
//                         sampled data and out_ready)
//  Revision    : 1.0 - initial release
// ============================================================================
interface acq_buffer_streamer_if #(
    parameter int DATA_W = 14,
    parameter int IDX_W  = 10
);
    logic              buffer_ready_A;
    logic              buffer_ready_B;
    logic [IDX_W:0]    sample_count_A;
    logic [IDX_W:0]    sample_count_B;
    logic [IDX_W-1:0]  read_index;
    logic [DATA_W-1:0] sampled_data_A;
    logic [DATA_W-1:0] sampled_data_B;
    logic [15:0]       out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    logic              busy;
    logic              frame_done;

    modport master (
        input  buffer_ready_A, buffer_ready_B,
        input  sample_count_A, sample_count_B,
        input  sampled_data_A, sampled_data_B,
        input  out_ready,
        output read_index,
        output out_data, out_valid, out_last,
        output busy, frame_done
    );

    modport slave (
        output buffer_ready_A, buffer_ready_B,
        output sample_count_A, sample_count_B,
        output sampled_data_A, sampled_data_B,
        output out_ready,
        input  read_index,
        input  out_data, out_valid, out_last,
        input  busy, frame_done
    );
endinterface
`default_nettype wire

// File: rtl/acq_buffer_streamer_read_delay.sv
`default_nettype none
// ============================================================================
//  Module      : acq_read_delay
//  Description : Capture strobe generator for the sampler read port.
//                While i_active is high (streamer in a FETCH state) it
//                counts cycles and raises o_capture in the cycle where the
//                read data for the current read_index is valid, i.e. the
//                (RD_LATENCY+1)-th FETCH cycle. With RD_LATENCY=0 the strobe
//                is the first FETCH cycle.
//  Ports       : clk, rst_n (async, active low), i_active, o_capture
//  Revision    : 1.0 - initial release
// ============================================================================
module acq_read_delay #(
    parameter int RD_LATENCY = 1
) (
    input  wire  clk,
    input  wire  rst_n,
    input  logic i_active,
    output logic o_capture
);

    generate
        if (RD_LATENCY == 0) begin : g_no_delay
            assign o_capture = i_active;
        end else begin : g_delay
            localparam int c_cnt_w = $clog2(RD_LATENCY + 1);
            localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(RD_LATENCY);
            localparam logic [c_cnt_w-1:0] c_one  = c_cnt_w'(1);

            logic [c_cnt_w-1:0] r_cnt;
            logic [c_cnt_w-1:0] w_cnt_nxt;
            logic               w_capture;

            assign w_capture = i_active && (r_cnt == c_last);

            // Counter restarts whenever the FETCH window closes, so each
            // read_index update gets a fresh latency window.
            always_comb begin
                w_cnt_nxt = '0;
                if (i_active && !w_capture) begin
                    w_cnt_nxt = r_cnt + c_one;
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= w_cnt_nxt;
                end
            end

            assign o_capture = w_capture;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/acq_buffer_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : acq_buffer_streamer
//  Description : Streams both sampler capture buffers as one framed 16-bit
//                word sequence: header A, samples A, header B, samples B.
//                Starts when both buffers are ready, re-arms only after both
//                ready flags have dropped. All outputs are registered.
//  Ports       : SYS_CLK  - system clock
//                RESET_N  - asynchronous active-low reset
//                bus      - master modport: ready flags, counts and sampled
//                           data in; read_index, out_data/valid/last,
//                           busy and frame_done out; out_ready in
//  Revision    : 1.0 - initial release
// ============================================================================
module acq_buffer_streamer
    import acq_buffer_streamer_pkg::*;
#(
    parameter int DATA_W     = 14,
    parameter int IDX_W      = 10,
    parameter int RD_LATENCY = 1
) (
    input  wire                   SYS_CLK,
    input  wire                   RESET_N,
    acq_buffer_streamer_if.master bus
);

    localparam logic [IDX_W:0]   c_depth   = (IDX_W+1)'(2**IDX_W);
    localparam logic [IDX_W:0]   c_one     = (IDX_W+1)'(1);
    localparam logic [IDX_W-1:0] c_idx_one = IDX_W'(1);

    state_t            r_state,  w_state_nxt;
    logic [IDX_W:0]    r_cnt_a,  w_cnt_a_nxt;
    logic [IDX_W:0]    r_cnt_b,  w_cnt_b_nxt;
    logic [IDX_W-1:0]  r_idx,    w_idx_nxt;
    logic [15:0]       r_data,   w_data_nxt;
    logic              r_valid,  w_valid_nxt;
    logic              r_last,   w_last_nxt;
    logic              r_busy,   w_busy_nxt;
    logic              r_done,   w_done_nxt;

    logic              w_hs;
    logic              w_fetch;
    logic              w_capture;
    logic              w_both_ready;
    logic              w_both_clear;
    logic [IDX_W:0]    w_clamp_a;
    logic [IDX_W:0]    w_clamp_b;
    logic [IDX_W:0]    w_idx_ext;
    logic              w_end_a;
    logic              w_end_b;
    logic [DATA_W-1:0] w_raw_a;
    logic [DATA_W-1:0] w_raw_b;
    logic [15:0]       w_hdr_b_word;
    logic              w_hdr_b_last;

    assign w_hs         = r_valid && bus.out_ready;
    assign w_fetch      = (r_state == S_FETCH_A) || (r_state == S_FETCH_B);
    assign w_both_ready = bus.buffer_ready_A && bus.buffer_ready_B;
    assign w_both_clear = !bus.buffer_ready_A && !bus.buffer_ready_B;

    // Counts above the buffer depth are treated as a full buffer.
    assign w_clamp_a = (bus.sample_count_A > c_depth) ? c_depth : bus.sample_count_A;
    assign w_clamp_b = (bus.sample_count_B > c_depth) ? c_depth : bus.sample_count_B;

    // Final-sample detection; only evaluated in states where count > 0.
    assign w_idx_ext = {1'b0, r_idx};
    assign w_end_a   = (w_idx_ext == (r_cnt_a - c_one));
    assign w_end_b   = (w_idx_ext == (r_cnt_b - c_one));

    assign w_raw_a = bus.sampled_data_A;
    assign w_raw_b = bus.sampled_data_B;

    // Header B is reached from two places; when channel B is empty it is
    // also the final word of the frame.
    assign w_hdr_b_word = make_word(TYPE_HDR_B, PAYLOAD_W'(r_cnt_b));
    assign w_hdr_b_last = (r_cnt_b == '0);

    acq_read_delay #(
        .RD_LATENCY (RD_LATENCY)
    ) u_read_delay (
        .clk       (SYS_CLK),
        .rst_n     (RESET_N),
        .i_active  (w_fetch),
        .o_capture (w_capture)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_a_nxt = r_cnt_a;
        w_cnt_b_nxt = r_cnt_b;
        w_idx_nxt   = r_idx;
        w_data_nxt  = r_data;
        w_valid_nxt = r_valid;
        w_last_nxt  = r_last;
        w_done_nxt  = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                w_idx_nxt = '0;
                if (w_both_ready) begin
                    w_cnt_a_nxt = w_clamp_a;
                    w_cnt_b_nxt = w_clamp_b;
                    w_data_nxt  = make_word(TYPE_HDR_A, PAYLOAD_W'(w_clamp_a));
                    w_valid_nxt = 1'b1;
                    w_last_nxt  = 1'b0;
                    w_state_nxt = S_HDR_A;
                end
            end

            S_HDR_A: begin
                if (w_hs) begin
                    if (r_cnt_a == '0) begin
                        w_data_nxt  = w_hdr_b_word;
                        w_last_nxt  = w_hdr_b_last;
                        w_state_nxt = S_HDR_B;
                    end else begin
                        w_idx_nxt   = '0;
                        w_valid_nxt = 1'b0;
                        w_state_nxt = S_FETCH_A;
                    end
                end
            end

            S_FETCH_A: begin
                if (w_capture) begin
                    w_data_nxt  = make_word(TYPE_SMP_A, PAYLOAD_W'(w_raw_a));
                    w_valid_nxt = 1'b1;
                    w_last_nxt  = 1'b0;
                    w_state_nxt = S_SEND_A;
                end
            end

            S_SEND_A: begin
                if (w_hs) begin
                    if (w_end_a) begin
                        w_data_nxt  = w_hdr_b_word;
                        w_last_nxt  = w_hdr_b_last;
                        w_state_nxt = S_HDR_B;
                    end else begin
                        w_idx_nxt   = r_idx + c_idx_one;
                        w_valid_nxt = 1'b0;
                        w_state_nxt = S_FETCH_A;
                    end
                end
            end

            S_HDR_B: begin
                if (w_hs) begin
                    w_valid_nxt = 1'b0;
                    if (r_cnt_b == '0) begin
                        w_last_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_WAIT_CLEAR;
                    end else begin
                        w_idx_nxt   = '0;
                        w_state_nxt = S_FETCH_B;
                    end
                end
            end

            S_FETCH_B: begin
                if (w_capture) begin
                    w_data_nxt  = make_word(TYPE_SMP_B, PAYLOAD_W'(w_raw_b));
                    w_valid_nxt = 1'b1;
                    w_last_nxt  = w_end_b;
                    w_state_nxt = S_SEND_B;
                end
            end

            S_SEND_B: begin
                if (w_hs) begin
                    w_valid_nxt = 1'b0;
                    if (w_end_b) begin
                        w_last_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_WAIT_CLEAR;
                    end else begin
                        w_idx_nxt   = r_idx + c_idx_one;
                        w_state_nxt = S_FETCH_B;
                    end
                end
            end

            S_WAIT_CLEAR: begin
                // Holding here until both flags fall prevents re-streaming
                // the same capture.
                w_valid_nxt = 1'b0;
                if (w_both_clear) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge SYS_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= S_IDLE;
            r_cnt_a <= '0;
            r_cnt_b <= '0;
            r_idx   <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt_a <= w_cnt_a_nxt;
            r_cnt_b <= w_cnt_b_nxt;
            r_idx   <= w_idx_nxt;
            r_data  <= w_data_nxt;
            r_valid <= w_valid_nxt;
            r_last  <= w_last_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign bus.read_index = r_idx;
    assign bus.out_data   = r_data;
    assign bus.out_valid  = r_valid;
    assign bus.out_last   = r_last;
    assign bus.busy       = r_busy;
    assign bus.frame_done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_acq_buffer_streamer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_acq_buffer_streamer
//  Description : Self-checking bench. Two streamer instances (read latency
//                1 and 3) share stimulus; each has its own sampler read-port
//                model, scoreboard queue and monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_acq_buffer_streamer;

    localparam int DW    = 14;
    localparam int IW    = 10;
    localparam int DEPTH = 1024;

    typedef struct packed {
        logic [15:0] w;
        logic        last;
        logic [IW:0] idx;
        logic        smp_next;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rdy_a = 1'b0;
    logic        rdy_b = 1'b0;
    logic [IW:0] cnt_a = '0;
    logic [IW:0] cnt_b = '0;
    logic        out_ready = 1'b1;
    bit          rnd_ready = 1'b0;

    logic [DW-1:0] mem_a [DEPTH];
    logic [DW-1:0] mem_b [DEPTH];

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   done_cnt [2];
    int   valid_seen [2];
    exp_t exp_q [2][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = rnd_ready ? 1'($urandom % 2) : 1'b1;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int L = (g == 0) ? 1 : 3;

        acq_buffer_streamer_if #(.DATA_W(DW), .IDX_W(IW)) bus ();

        assign bus.buffer_ready_A = rdy_a;
        assign bus.buffer_ready_B = rdy_b;
        assign bus.sample_count_A = cnt_a;
        assign bus.sample_count_B = cnt_b;
        assign bus.out_ready      = out_ready;

        acq_buffer_streamer #(
            .DATA_W     (DW),
            .IDX_W      (IW),
            .RD_LATENCY (L)
        ) u_dut (
            .SYS_CLK (clk),
            .RESET_N (rst_n),
            .bus     (bus.master)
        );

        // Sampler read port: data reflects read_index as it was L edges ago.
        logic [IW-1:0] idx_d [4];
        always @(posedge clk) begin
            idx_d[0] <= bus.read_index;
            for (int i = 1; i < 4; i++) idx_d[i] <= idx_d[i-1];
        end
        assign bus.sampled_data_A = mem_a[idx_d[L-1]];
        assign bus.sampled_data_B = mem_b[idx_d[L-1]];

        bit          prev_stall, was_valid, lat_pend;
        logic [15:0] prev_data;
        logic        prev_last;
        int          hs_cyc;
        exp_t        e;

        always @(negedge clk) begin
            if (!rst_n) begin
                prev_stall = 0;
                was_valid  = 0;
                lat_pend   = 0;
            end else begin
                if (prev_stall) begin
                    checks++;
                    if (!bus.out_valid || bus.out_data !== prev_data || bus.out_last !== prev_last) begin
                        failures++;
                        $display("FAIL stall_hold[%0d] valid=%b data=%h last=%b required valid=1 data=%h last=%b",
                                 g, bus.out_valid, bus.out_data, bus.out_last, prev_data, prev_last);
                    end
                end
                if (bus.out_valid && !was_valid && lat_pend) begin
                    checks++;
                    if (cyc - hs_cyc != L + 2) begin
                        failures++;
                        $display("FAIL valid_latency[%0d] gap=%0d required=%0d", g, cyc - hs_cyc, L + 2);
                    end
                    lat_pend = 0;
                end
                if (bus.out_valid) valid_seen[g]++;
                if (bus.out_valid && bus.out_ready) begin
                    checks++;
                    if (exp_q[g].size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_word[%0d] data=%h required none", g, bus.out_data);
                    end else begin
                        e = exp_q[g].pop_front();
                        if (bus.out_data !== e.w || bus.out_last !== e.last ||
                            (e.w[15] == 1'b0 && {1'b0, bus.read_index} !== e.idx)) begin
                            failures++;
                            $display("FAIL word[%0d] data=%h last=%b idx=%0d required data=%h last=%b idx=%0d",
                                     g, bus.out_data, bus.out_last, bus.read_index, e.w, e.last, e.idx);
                        end
                        lat_pend = e.smp_next;
                        hs_cyc   = cyc;
                    end
                end
                if (bus.frame_done) done_cnt[g]++;
                prev_stall = bus.out_valid && !bus.out_ready;
                prev_data  = bus.out_data;
                prev_last  = bus.out_last;
                was_valid  = bus.out_valid;
            end
        end
    end

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Reference frame: pure list of words derived from counts and buffer contents.
    task automatic push_frame(input int ca_raw, input int cb_raw);
        int   ca, cb;
        exp_t e;
        ca = (ca_raw > DEPTH) ? DEPTH : ca_raw;
        cb = (cb_raw > DEPTH) ? DEPTH : cb_raw;
        for (int k = 0; k < 2; k++) begin
            e = '{w: {2'b10, 14'(ca)}, last: 1'b0, idx: '0, smp_next: (ca > 0)};
            exp_q[k].push_back(e);
            for (int i = 0; i < ca; i++) begin
                e = '{w: {2'b00, mem_a[i]}, last: 1'b0, idx: 11'(i), smp_next: (i < ca - 1)};
                exp_q[k].push_back(e);
            end
            e = '{w: {2'b11, 14'(cb)}, last: (cb == 0), idx: '0, smp_next: (cb > 0)};
            exp_q[k].push_back(e);
            for (int i = 0; i < cb; i++) begin
                e = '{w: {2'b01, mem_b[i]}, last: (i == cb - 1), idx: 11'(i), smp_next: (i < cb - 1)};
                exp_q[k].push_back(e);
            end
        end
    endtask

    task automatic fill_mem(input int pat);
        for (int i = 0; i < DEPTH; i++) begin
            mem_a[i] = (pat == 0) ? DW'(i + 100) : DW'($urandom);
            mem_b[i] = (pat == 0) ? DW'(i + 200) : DW'($urandom);
        end
    endtask

    task automatic wait_done(input int b0, input int b1, input int limit);
        int n;
        n = 0;
        while ((done_cnt[0] <= b0 || done_cnt[1] <= b1) && n < limit) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (n >= limit) begin
            failures++;
            $display("FAIL frame_timeout cycles=%0d required<%0d", n, limit);
        end
    endtask

    task automatic finish_frame(input int b0, input int b1, input bit hold);
        int v0, v1;
        chk("queue_empty0", exp_q[0].size(), 0);
        chk("queue_empty1", exp_q[1].size(), 0);
        if (hold) begin
            v0 = valid_seen[0];
            v1 = valid_seen[1];
            repeat (10) @(posedge clk);
            #1;
            chk("wait_clear_quiet0", valid_seen[0] - v0, 0);
            chk("wait_clear_quiet1", valid_seen[1] - v1, 0);
            chk("wait_clear_busy0", g_dut[0].bus.busy, 1);
            chk("wait_clear_busy1", g_dut[1].bus.busy, 1);
        end
        chk("done_pulses0", done_cnt[0] - b0, 1);
        chk("done_pulses1", done_cnt[1] - b1, 1);
        @(posedge clk);
        #1;
        rdy_a = 1'b0;
        rdy_b = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("idle_busy0", g_dut[0].bus.busy, 0);
        chk("idle_busy1", g_dut[1].bus.busy, 0);
    endtask

    task automatic run_frame(input int ca, input int cb, input int pat, input bit rr,
                             input bit drop_mid, input int limit);
        int b0, b1;
        b0 = done_cnt[0];
        b1 = done_cnt[1];
        fill_mem(pat);
        rnd_ready = rr;
        @(posedge clk);
        #1;
        cnt_a = (IW+1)'(ca);
        cnt_b = (IW+1)'(cb);
        rdy_a = 1'b1;
        rdy_b = 1'b1;
        push_frame(ca, cb);
        if (drop_mid) begin
            repeat (5) @(posedge clk);
            #1;
            rdy_a = 1'b0;
            rdy_b = 1'b0;
        end
        wait_done(b0, b1, limit);
        finish_frame(b0, b1, !drop_mid);
        rnd_ready = 1'b0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_zero0"}, {g_dut[0].bus.read_index, g_dut[0].bus.out_data, g_dut[0].bus.out_valid,
                              g_dut[0].bus.out_last, g_dut[0].bus.busy, g_dut[0].bus.frame_done}, 0);
        chk({tag, "_zero1"}, {g_dut[1].bus.read_index, g_dut[1].bus.out_data, g_dut[1].bus.out_valid,
                              g_dut[1].bus.out_last, g_dut[1].bus.busy, g_dut[1].bus.frame_done}, 0);
    endtask

    initial begin
        int b0, b1, n;
        done_cnt   = '{0, 0};
        valid_seen = '{0, 0};

        #12;
        chk_zero("reset");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Directed frames
        run_frame(4, 3, 0, 1'b0, 1'b0, 2000);
        run_frame(4, 3, 0, 1'b1, 1'b0, 4000);
        run_frame(0, 2, 1, 1'b0, 1'b0, 2000);
        run_frame(0, 0, 1, 1'b1, 1'b0, 2000);
        run_frame(1500, 3, 1, 1'b0, 1'b0, 20000);
        run_frame(3, 1024, 1, 1'b0, 1'b0, 20000);

        // Randomized frames
        for (int f = 0; f < 8; f++) begin
            run_frame(($urandom % 5 == 0) ? 0 : int'($urandom_range(1, 24)),
                      ($urandom % 5 == 0) ? 0 : int'($urandom_range(1, 24)),
                      1, 1'($urandom % 2), 1'($urandom % 3 == 0), 4000);
        end

        // Reset while channel A samples are being sent
        fill_mem(1);
        rnd_ready = 1'b0;
        @(posedge clk);
        #1;
        cnt_a = 11'd8;
        cnt_b = 11'd2;
        rdy_a = 1'b1;
        rdy_b = 1'b1;
        push_frame(8, 2);
        n = 0;
        while (n < 200 && !(g_dut[0].bus.out_valid && g_dut[0].bus.out_data[15:14] == 2'b00)) begin
            @(negedge clk);
            n++;
        end
        chk("reach_send_a", (n < 200), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("async_reset");
        exp_q[0].delete();
        exp_q[1].delete();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        b0 = done_cnt[0];
        b1 = done_cnt[1];
        push_frame(8, 2);
        wait_done(b0, b1, 2000);
        finish_frame(b0, b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
